// File: rtl/button_pulse_conditioner.sv
// Push-button front end: per-button synchroniser, debounce, press pulse and
// optional auto-repeat, followed by arbitration onto registered one-cycle strobes.

module bpc_button #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic raw_pulse_o,
  output logic active_o
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             s1_q, s2_q;
  state_t           state_q;
  logic [CNT_W-1:0] db_cnt_q, rep_cnt_q;
  logic             first_done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A pulse fires on the edge the counter completes its interval.
  always_comb begin
    raw_pulse_o = 1'b0;
    case (state_q)
      PRESS_DB: raw_pulse_o = s2_q && (db_cnt_q == DB_LAST);
      HELD:     raw_pulse_o = REPEAT_EN && s2_q &&
                              (rep_cnt_q == (first_done_q ? RATE_LAST : DELAY_LAST));
      default:  raw_pulse_o = 1'b0;
    endcase
  end

  assign active_o = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      rep_cnt_q    <= '0;
      first_done_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q  <= PRESS_DB;
            db_cnt_q <= CNT_W'(1);
          end else begin
            db_cnt_q <= '0;
          end
        end
        PRESS_DB: begin
          if (!s2_q) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q      <= HELD;
            db_cnt_q     <= '0;
            rep_cnt_q    <= '0;
            first_done_q <= 1'b0;
          end else begin
            db_cnt_q <= sat_inc(db_cnt_q);
          end
        end
        HELD: begin
          if (!s2_q) begin
            state_q  <= REL_DB;
            db_cnt_q <= CNT_W'(1);
          end else if (REPEAT_EN) begin
            if (raw_pulse_o) begin
              rep_cnt_q    <= '0;
              first_done_q <= 1'b1;
            end else begin
              rep_cnt_q <= sat_inc(rep_cnt_q);
            end
          end
        end
        REL_DB: begin
          // Repeat counter is left untouched so a bounce resumes the hold.
          if (s2_q) begin
            state_q  <= HELD;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= sat_inc(db_cnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_up,
  input  logic btn_down,
  output logic pulsed_set,
  output logic pulsed_up,
  output logic pulsed_down,
  output logic busy
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  logic set_raw, up_raw, down_raw;
  logic set_act, up_act, down_act;
  logic set_q, up_q, down_q, busy_q;
  logic set_d, up_d, down_d, busy_d;

  bpc_button #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0), .CNT_W(CNT_W)
  ) u_set (
    .clk(clk), .rst_n(reset), .btn_i(btn_set), .raw_pulse_o(set_raw), .active_o(set_act)
  );

  bpc_button #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1), .CNT_W(CNT_W)
  ) u_up (
    .clk(clk), .rst_n(reset), .btn_i(btn_up), .raw_pulse_o(up_raw), .active_o(up_act)
  );

  bpc_button #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1), .CNT_W(CNT_W)
  ) u_down (
    .clk(clk), .rst_n(reset), .btn_i(btn_down), .raw_pulse_o(down_raw), .active_o(down_act)
  );

  // SET wins over UP/DOWN; simultaneous UP and DOWN cancel each other.
  assign set_d  = set_raw;
  assign up_d   = up_raw   & ~set_raw & ~down_raw;
  assign down_d = down_raw & ~set_raw & ~up_raw;
  assign busy_d = set_act | up_act | down_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_q  <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      set_q  <= set_d;
      up_q   <= up_d;
      down_q <= down_d;
      busy_q <= busy_d;
    end
  end

  assign pulsed_set  = set_q;
  assign pulsed_up   = up_q;
  assign pulsed_down = down_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner with short debounce/repeat intervals.

module tb_button_pulse_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_set = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic pulsed_set, pulsed_up, pulsed_down, busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] which;
  } exp_t;

  exp_t sb[$];

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down),
    .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe seen must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && (pulsed_set || pulsed_up || pulsed_down)) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse cyc=%0d got {set,up,down}=%b required=no pulse",
                 cyc, {pulsed_set, pulsed_up, pulsed_down});
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.which != {pulsed_set, pulsed_up, pulsed_down}) begin
          errors = errors + 1;
          $display("FAIL pulse cyc=%0d got {set,up,down}=%b required cyc=%0d {set,up,down}=%b",
                   cyc, {pulsed_set, pulsed_up, pulsed_down}, e.cyc, e.which);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [2:0] w);
    exp_t e;
    e.cyc = c;
    e.which = w;
    sb.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
    end
  endtask

  task automatic hold_btns(input logic [2:0] b, input int n);
    {btn_set, btn_up, btn_down} = b;
    tick(n);
    {btn_set, btn_up, btn_down} = 3'b000;
  endtask

  initial begin
    int k;
    int r;
    logic [4:0] bounce;
    bounce = 5'b10110;

    tick(2);
    check_bit("reset_pulsed_set", pulsed_set, 1'b0);
    check_bit("reset_pulsed_up", pulsed_up, 1'b0);
    check_bit("reset_pulsed_down", pulsed_down, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    reset = 1'b1;
    tick(3);

    // Clean UP press held 12 cycles: one pulse, no repeat.
    k = cyc + 1;
    push_exp(k + 5, 3'b010);
    hold_btns(3'b010, 12);
    tick(3);
    check_bit("t1_busy_release_db", busy, 1'b1);
    tick(11);
    check_bit("t1_busy_idle", busy, 1'b0);
    tick(5);

    // UP held 40 cycles: initial pulse plus repeats at +20, then every 5.
    k = cyc + 1;
    push_exp(k + 5, 3'b010);
    push_exp(k + 25, 3'b010);
    push_exp(k + 30, 3'b010);
    push_exp(k + 35, 3'b010);
    push_exp(k + 40, 3'b010);
    hold_btns(3'b010, 40);
    tick(20);

    // SET bounce 1,0,1,1,0 then stable for 50 cycles: a single pulse.
    for (int i = 4; i >= 0; i--) begin
      btn_set = bounce[i];
      tick(1);
    end
    k = cyc + 1;
    push_exp(k + 5, 3'b100);
    hold_btns(3'b100, 50);
    tick(15);

    // UP and DOWN together: presses and repeats all cancelled.
    hold_btns(3'b011, 40);
    tick(20);
    check_bit("t4_busy_idle", busy, 1'b0);

    // SET and UP together: SET wins, UP repeat still appears later.
    k = cyc + 1;
    push_exp(k + 5, 3'b100);
    push_exp(k + 25, 3'b010);
    hold_btns(3'b110, 26);
    tick(20);

    // Reset pulsed mid-hold: outputs clear at once, press is re-debounced.
    k = cyc + 1;
    push_exp(k + 5, 3'b010);
    btn_up = 1'b1;
    tick(10);
    check_bit("t6_busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("t6_busy_in_reset", busy, 1'b0);
    check_bit("t6_pulsed_up_in_reset", pulsed_up, 1'b0);
    tick(1);
    reset = 1'b1;
    r = cyc + 1;
    push_exp(r + 5, 3'b010);
    tick(10);
    btn_up = 1'b0;
    tick(20);

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_pulses got outstanding=%0d required=0 next_cyc=%0d",
               sb.size(), sb[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
